i2c_slave_responder: RTL
========================

// Module: i2c_slave_responder
// PURPOSE
//  I2C target (responder) for the open-drain bus driven by the team's I2C master controller.
//  - Detects START, repeated START and STOP; matches one 7-bit address.
//  - Write transfers: presents each received byte to the fabric and ACKs it.
//  - Read transfers: fetches bytes from the fabric and holds SCL low (clock stretching) until
//    the fabric has a byte ready.
//  - Sits at the board pins, opposite the master, on the same sda/scl wires.
// PARAMETERS
//  ADDR      7'h50  own 7-bit slave address
//  FILTER    3      clocks a synchronized SCL/SDA level must be stable before it is accepted (1..7)
// PORTS
//  clk          in     1  system clock; must be >= 20x SCL
//  reset        in     1  asynchronous, active-low reset
//  sda          inout  1  I2C data; driven 1'b0 or 1'bz only
//  scl          inout  1  I2C clock; driven 1'b0 (stretch) or 1'bz only
//  busy         out    1  high from accepted START to accepted STOP
//  selected     out    1  high from address ACK to the next START or STOP
//  rw           out    1  R/W bit of the current transfer (1 = read)
//  datareceive  out    8  last byte written by the master
//  received     out    1  one-clk pulse: datareceive updated (data byte only, never the address)
//  datasend     in     8  byte to return on a read
//  sendvalid    in     1  datasend is valid; sampled only in state LOAD
//  sended       out    1  one-clk pulse: datasend captured into the shift register
//  state        out    4  current FSM state code, for debug
// BEHAVIOUR
//  Reset (async, reset=0): sda=z, scl=z, busy=0, selected=0, rw=0, datareceive=8'h00,
//   received=0, sended=0, state=IDLE, bit counter=7, filters preset to 1.
//  Input path: 2-FF synchronizer, then FILTER-cycle glitch filter.
//   Events are generated on the filtered levels s_scl/s_sda.
//   START = s_sda 1->0 while s_scl=1. STOP = s_sda 0->1 while s_scl=1.
//   RISE/FALL = s_scl edges. Each event is a one-clk strobe.
//  Priority in any state: STOP -> IDLE (busy=0, selected=0, release both lines).
//   START -> ADDR (busy=1, selected=0, counter=7); this is also the repeated-START path.
//  Data bits: sample s_sda on RISE, MSB first. Change the driven sda only on FALL.
//  FSM states:
//   0 IDLE:     lines released; wait for START.
//   1 ADDR:     shift 8 bits; after the 8th RISE, compare bits[7:1] with ADDR.
//               Match: rw=bit0, go ADDR_ACK on the next FALL. Mismatch: go IGNORE.
//   2 ADDR_ACK: drive sda=0 from that FALL until the following FALL; selected=1.
//               Then go WR_DATA if rw=0, or LOAD if rw=1.
//   3 WR_DATA:  shift 8 bits. On the 8th RISE: datareceive<=byte, received=1 for one clk.
//               Next FALL -> WR_ACK.
//   4 WR_ACK:   sda=0 until next FALL, then WR_DATA. The slave always ACKs.
//   5 LOAD:     hold scl=0 (stretch) while sendvalid=0.
//               When sendvalid=1: shift<=datasend, sended=1 for one clk, drive MSB, release scl,
//               go RD_DATA. Entered right after a FALL, so SCL is already low.
//   6 RD_DATA:  drive sda=z if the bit is 1, else 0; advance bit on each FALL.
//               After the 8th FALL, release sda and go RD_ACK.
//   7 RD_ACK:   sample master ACK on RISE. ACK(0): next FALL -> LOAD.
//               NACK(1): IGNORE (sda released until STOP or START).
//   8 IGNORE:   lines released; wait for STOP or START.
//  Counter: 4-bit, 7 down to 0, reloads 7 on entering ADDR/WR_DATA/RD_DATA.
//  Boundaries:
//   - General call (0x00) is not acknowledged.
//   - START in mid-byte aborts the byte; datareceive and received are unaffected.
//   - STOP during LOAD releases scl immediately, with no sended pulse.
//   - sendvalid already high on LOAD entry: capture in the first LOAD clk, so the stretch is <=1 clk.
//   - received and sended are never asserted in the same clk.
//   - reset mid-transfer releases both lines within the same clk (async).
// TESTING
//  1 Write 0xA0 (addr 0x50 W), 0x3C, 0xFF, STOP -> ACK on all 3 bytes; received pulses twice;
//    datareceive=0x3C then 0xFF; busy falls after STOP.
//  2 Read 0xA1, sendvalid held 0 for 500 clk then datasend=0x96 -> SCL held low ~500 clk;
//    one sended pulse; master reads 0x96; master NACK -> IGNORE; STOP -> IDLE.
//  3 Address 0xA2 (addr 0x51) -> no ACK (SDA high on 9th clock); state IGNORE;
//    selected=0; received never pulses.
//  4 Write 0xA0, 0x11, repeated START, 0xA1, read 2 bytes 0x5A,0xC3 with ACK then NACK
//    -> rw 0->1; two sended pulses; bytes correct.
//  5 1-clk glitch on SCL during WR_DATA (FILTER=3) -> no extra bit; byte 0x3C received intact.
//  6 Assert reset during RD_DATA with sda low -> sda=z, scl=z immediately;
//    all outputs at reset values; next START decoded normally.

Source files
------------

// File: rtl/i2c_slave_responder_if.sv
// Fabric-side handshake of the I2C responder: write bytes flow out to the fabric,
// read bytes flow in from it. "slave" is the responder's view, "master" the fabric's.
interface i2c_slave_responder_if;
    logic       busy;
    logic       selected;
    logic       rw;
    logic [7:0] datareceive;
    logic       received;
    logic [7:0] datasend;
    logic       sendvalid;
    logic       sended;

    modport slave (
        output busy, selected, rw, datareceive, received, sended,
        input  datasend, sendvalid
    );

    modport master (
        input  busy, selected, rw, datareceive, received, sended,
        output datasend, sendvalid
    );
endinterface

// File: rtl/i2c_slave_responder.sv
// I2C target on the open-drain sda/scl pins: one 7-bit address, ACKs every written byte,
// stretches SCL in LOAD until the fabric offers a read byte.
module i2c_slave_responder #(
    parameter logic [6:0]  ADDR   = 7'h50,
    parameter int unsigned FILTER = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    inout  wire                   sda,
    inout  wire                   scl,
    i2c_slave_responder_if.slave  fab,
    output logic [3:0]            state
);
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_WR_DATA  = 4'd3,
        ST_WR_ACK   = 4'd4,
        ST_LOAD     = 4'd5,
        ST_RD_DATA  = 4'd6,
        ST_RD_ACK   = 4'd7,
        ST_IGNORE   = 4'd8
    } state_t;

    localparam logic [2:0] FLT_MAX = 3'(FILTER - 1);

    logic [1:0] scl_sync, sda_sync;
    logic [2:0] scl_cnt, sda_cnt;
    logic       s_scl, s_sda, scl_q, sda_q;
    logic       start_ev, stop_ev, rise_ev, fall_ev;

    state_t     st, st_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] shift, shift_n;
    logic       sda_low, sda_low_n, scl_low, scl_low_n;
    logic       busy_q, busy_n, sel_q, sel_n, rw_q, rw_n;
    logic [7:0] rx_q, rx_n;
    logic       rcv_q, rcv_n, snd_q, snd_n;

    // A new level is accepted only after FILTER consecutive clocks of disagreement.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_cnt  <= 3'd0;
            sda_cnt  <= 3'd0;
            s_scl    <= 1'b1;
            s_sda    <= 1'b1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_q    <= s_scl;
            sda_q    <= s_sda;
            if (scl_sync[1] != s_scl) begin
                if (scl_cnt == FLT_MAX) begin
                    s_scl   <= scl_sync[1];
                    scl_cnt <= 3'd0;
                end else begin
                    scl_cnt <= scl_cnt + 3'd1;
                end
            end else begin
                scl_cnt <= 3'd0;
            end
            if (sda_sync[1] != s_sda) begin
                if (sda_cnt == FLT_MAX) begin
                    s_sda   <= sda_sync[1];
                    sda_cnt <= 3'd0;
                end else begin
                    sda_cnt <= sda_cnt + 3'd1;
                end
            end else begin
                sda_cnt <= 3'd0;
            end
        end
    end

    assign start_ev = scl_q & s_scl & sda_q & ~s_sda;
    assign stop_ev  = scl_q & s_scl & ~sda_q & s_sda;
    assign rise_ev  = ~scl_q & s_scl;
    assign fall_ev  = scl_q & ~s_scl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st      <= ST_IDLE;
            cnt     <= 4'd7;
            shift   <= 8'h00;
            sda_low <= 1'b0;
            scl_low <= 1'b0;
            busy_q  <= 1'b0;
            sel_q   <= 1'b0;
            rw_q    <= 1'b0;
            rx_q    <= 8'h00;
            rcv_q   <= 1'b0;
            snd_q   <= 1'b0;
        end else begin
            st      <= st_n;
            cnt     <= cnt_n;
            shift   <= shift_n;
            sda_low <= sda_low_n;
            scl_low <= scl_low_n;
            busy_q  <= busy_n;
            sel_q   <= sel_n;
            rw_q    <= rw_n;
            rx_q    <= rx_n;
            rcv_q   <= rcv_n;
            snd_q   <= snd_n;
        end
    end

    // cnt counts 7..0 per byte; wrapping to 4'hF marks "8 bits seen, wait for FALL".
    always_comb begin
        st_n      = st;
        cnt_n     = cnt;
        shift_n   = shift;
        sda_low_n = sda_low;
        scl_low_n = scl_low;
        busy_n    = busy_q;
        sel_n     = sel_q;
        rw_n      = rw_q;
        rx_n      = rx_q;
        rcv_n     = 1'b0;
        snd_n     = 1'b0;
        if (stop_ev) begin
            st_n      = ST_IDLE;
            busy_n    = 1'b0;
            sel_n     = 1'b0;
            sda_low_n = 1'b0;
            scl_low_n = 1'b0;
        end else if (start_ev) begin
            st_n      = ST_ADDR;
            busy_n    = 1'b1;
            sel_n     = 1'b0;
            cnt_n     = 4'd7;
            sda_low_n = 1'b0;
            scl_low_n = 1'b0;
        end else begin
            case (st)
                ST_ADDR: begin
                    if (rise_ev) begin
                        shift_n = {shift[6:0], s_sda};
                        cnt_n   = cnt - 4'd1;
                        if (cnt == 4'd0) begin
                            // General call is never claimed, even if ADDR were 0.
                            if (shift[6:0] != ADDR || shift[6:0] == 7'h00) st_n = ST_IGNORE;
                            else                                          rw_n = s_sda;
                        end
                    end else if (fall_ev && cnt[3]) begin
                        st_n      = ST_ADDR_ACK;
                        sda_low_n = 1'b1;
                        sel_n     = 1'b1;
                    end
                end
                ST_ADDR_ACK: begin
                    if (fall_ev) begin
                        sda_low_n = 1'b0;
                        if (rw_q) begin
                            st_n      = ST_LOAD;
                            scl_low_n = 1'b1;
                        end else begin
                            st_n  = ST_WR_DATA;
                            cnt_n = 4'd7;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (rise_ev) begin
                        shift_n = {shift[6:0], s_sda};
                        cnt_n   = cnt - 4'd1;
                        if (cnt == 4'd0) begin
                            rx_n  = {shift[6:0], s_sda};
                            rcv_n = 1'b1;
                        end
                    end else if (fall_ev && cnt[3]) begin
                        st_n      = ST_WR_ACK;
                        sda_low_n = 1'b1;
                    end
                end
                ST_WR_ACK: begin
                    if (fall_ev) begin
                        sda_low_n = 1'b0;
                        st_n      = ST_WR_DATA;
                        cnt_n     = 4'd7;
                    end
                end
                ST_LOAD: begin
                    if (fab.sendvalid) begin
                        shift_n   = fab.datasend;
                        snd_n     = 1'b1;
                        sda_low_n = ~fab.datasend[7];
                        scl_low_n = 1'b0;
                        cnt_n     = 4'd7;
                        st_n      = ST_RD_DATA;
                    end else begin
                        scl_low_n = 1'b1;
                    end
                end
                ST_RD_DATA: begin
                    if (fall_ev) begin
                        cnt_n = cnt - 4'd1;
                        if (cnt == 4'd0) begin
                            sda_low_n = 1'b0;
                            st_n      = ST_RD_ACK;
                        end else begin
                            shift_n   = {shift[6:0], 1'b0};
                            sda_low_n = ~shift[6];
                        end
                    end
                end
                ST_RD_ACK: begin
                    // cnt==0 here means the master ACKed on the preceding RISE.
                    if (rise_ev) begin
                        if (s_sda) st_n  = ST_IGNORE;
                        else       cnt_n = 4'd0;
                    end else if (fall_ev && cnt == 4'd0) begin
                        st_n      = ST_LOAD;
                        scl_low_n = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sda             = sda_low ? 1'b0 : 1'bz;
    assign scl             = scl_low ? 1'b0 : 1'bz;
    assign state           = st;
    assign fab.busy        = busy_q;
    assign fab.selected    = sel_q;
    assign fab.rw          = rw_q;
    assign fab.datareceive = rx_q;
    assign fab.received    = rcv_q;
    assign fab.sended      = snd_q;
endmodule
